trena_serial_seq_uc: RTL and testbench

//  Parametrised control unit for the measure-then-transmit flow of the digital tape measure.

---
 rtl/trena_serial_seq_uc.sv | 156 +++++++++++++++
 tb/tb_trena_serial_seq_uc.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/trena_serial_seq_uc.sv
// Measure-then-transmit sequencer for the tape measure: one measurement, then N_DIGITS
// characters (plus an optional terminator) over the serial TX, one per handshake.
module trena_serial_seq_uc #(
    parameter  int N_DIGITS       = 3,
    parameter  int HAS_TERMINATOR = 1,
    parameter  int TIMEOUT_CYCLES = 50000000,
    parameter  int PERIOD_CYCLES  = 25000000,
    localparam int IW             = $clog2(N_DIGITS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mensurar,
    input  logic          continuo,
    input  logic          medida_pronto,
    input  logic          envio_pronto,
    output logic          medir,
    output logic          transmitir,
    output logic [IW-1:0] sel_digito,
    output logic          pronto,
    output logic          timeout,
    output logic [3:0]    db_estado
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_MSD  = IW'(N_DIGITS - 1);
    localparam logic [IW-1:0] IDX_TERM = IW'(N_DIGITS);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        FAZ_MEDIDA     = 4'h1,
        AGUARDA_MEDIDA = 4'h2,
        TRANSMITE      = 4'h3,
        ESPERA_TX      = 4'h4,
        INTERVALO      = 4'h6,
        ERRO           = 4'hE,
        FIM            = 4'hF
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_tmo;
    logic [PW-1:0] r_per;
    logic          r_timeout;

    logic w_tmo_done;
    logic w_per_done;
    logic w_idx_term;
    logic w_idx_zero;

    assign w_tmo_done = (r_tmo == TMO_LAST);
    assign w_per_done = (r_per == PER_LAST);
    // idx == N_DIGITS only ever addresses the terminator, so it doubles as "terminator sent"
    assign w_idx_term = (r_idx == IDX_TERM);
    assign w_idx_zero = (r_idx == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= INICIAL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        medir      = 1'b0;
        transmitir = 1'b0;
        pronto     = 1'b0;
        db_estado  = r_state;
        case (r_state)
            INICIAL: begin
                if (mensurar) w_next = FAZ_MEDIDA;
            end
            FAZ_MEDIDA: begin
                medir  = 1'b1;
                w_next = AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: begin
                if (medida_pronto)   w_next = TRANSMITE;
                else if (w_tmo_done) w_next = ERRO;
            end
            TRANSMITE: begin
                transmitir = 1'b1;
                w_next     = ESPERA_TX;
            end
            ESPERA_TX: begin
                if (envio_pronto) begin
                    if (w_idx_term)               w_next = FIM;
                    else if (!w_idx_zero)         w_next = TRANSMITE;
                    else if (HAS_TERMINATOR != 0) w_next = TRANSMITE;
                    else                          w_next = FIM;
                end
            end
            FIM: begin
                pronto = 1'b1;
                w_next = continuo ? INTERVALO : INICIAL;
            end
            INTERVALO: begin
                if (!continuo)       w_next = INICIAL;
                else if (w_per_done) w_next = FAZ_MEDIDA;
            end
            ERRO: begin
                w_next = INICIAL;
            end
            default: begin
                w_next    = INICIAL;
                db_estado = 4'hD;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx     <= IDX_MSD;
            r_tmo     <= '0;
            r_per     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                FAZ_MEDIDA: begin
                    r_idx     <= IDX_MSD;
                    r_tmo     <= '0;
                    r_timeout <= 1'b0;
                end
                AGUARDA_MEDIDA: begin
                    if (!medida_pronto) begin
                        if (w_tmo_done) r_timeout <= 1'b1;
                        else            r_tmo     <= r_tmo + 1'b1;
                    end
                end
                ESPERA_TX: begin
                    if (envio_pronto && !w_idx_term) begin
                        if (!w_idx_zero)              r_idx <= r_idx - 1'b1;
                        else if (HAS_TERMINATOR != 0) r_idx <= IDX_TERM;
                    end
                end
                FIM: begin
                    if (continuo) r_per <= '0;
                end
                INTERVALO: begin
                    if (continuo && !w_per_done) r_per <= r_per + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sel_digito = r_idx;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_trena_serial_seq_uc.sv
// Bench for trena_serial_seq_uc: two instances (3 digits + terminator, 5 digits without),
// driven by randomized measurement/TX response delays and checked against a frame timing model.
module tb_trena_serial_seq_uc;

    localparam int TMO = 20;
    localparam int PER = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       mens_a = 1'b0, mens_b = 1'b0, continuo = 1'b0;
    logic       meas_a = 1'b0, meas_b = 1'b0, rsp_a = 1'b0, rsp_b = 1'b0;
    logic       spur_en = 1'b0;
    logic       env_a, env_b;
    logic       medir_a, tx_a, pro_a, tmo_a;
    logic       medir_b, tx_b, pro_b, tmo_b;
    logic [1:0] sel_a;
    logic [2:0] sel_b;
    logic [3:0] db_a, db_b;

    // spurious envio_pronto while waiting for the measurement or while transmitir is up
    assign env_a = rsp_a | (spur_en & (db_a == 4'h2 || db_a == 4'h3));
    assign env_b = rsp_b | (spur_en & (db_b == 4'h2 || db_b == 4'h3));

    trena_serial_seq_uc #(.N_DIGITS(3), .HAS_TERMINATOR(1), .TIMEOUT_CYCLES(TMO), .PERIOD_CYCLES(PER)) dut_a (
        .clock(clk), .reset(rst_n), .mensurar(mens_a), .continuo(continuo),
        .medida_pronto(meas_a), .envio_pronto(env_a), .medir(medir_a), .transmitir(tx_a),
        .sel_digito(sel_a), .pronto(pro_a), .timeout(tmo_a), .db_estado(db_a));

    trena_serial_seq_uc #(.N_DIGITS(5), .HAS_TERMINATOR(0), .TIMEOUT_CYCLES(TMO), .PERIOD_CYCLES(PER)) dut_b (
        .clock(clk), .reset(rst_n), .mensurar(mens_b), .continuo(continuo),
        .medida_pronto(meas_b), .envio_pronto(env_b), .medir(medir_b), .transmitir(tx_b),
        .sel_digito(sel_b), .pronto(pro_b), .timeout(tmo_b), .db_estado(db_b));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // environment: measurement interface answers meas_dly cycles after medir, TX rsp_dly after transmitir
    int  rsp_dly = 3, meas_dly = 5;
    bit  meas_en = 1'b1;
    int  cnt_a = 0, cnt_b = 0, cm_a = 0, cm_b = 0;
    always @(negedge clk) begin
        rsp_a = 1'b0; rsp_b = 1'b0; meas_a = 1'b0; meas_b = 1'b0;
        if (!rst_n) begin
            cnt_a = 0; cnt_b = 0; cm_a = 0; cm_b = 0;
        end else begin
            if (cnt_a > 0) begin cnt_a--; if (cnt_a == 0) rsp_a = 1'b1; end
            if (cnt_b > 0) begin cnt_b--; if (cnt_b == 0) rsp_b = 1'b1; end
            if (cm_a > 0) begin cm_a--; if (cm_a == 0) meas_a = 1'b1; end
            if (cm_b > 0) begin cm_b--; if (cm_b == 0) meas_b = 1'b1; end
            if (tx_a) cnt_a = rsp_dly;
            if (tx_b) cnt_b = rsp_dly;
            if (medir_a && meas_en) cm_a = meas_dly;
            if (medir_b && meas_en) cm_b = meas_dly;
        end
    end

    // event log per instance (0 = A, 1 = B)
    int med_n[2], tx_n[2], pro_n[2];
    int med_cyc[2][64], tx_cyc[2][64], tx_sel[2][64], pro_cyc[2][64];
    always @(negedge clk) begin
        if (rst_n) begin
            if (medir_a && med_n[0] < 64) begin med_cyc[0][med_n[0]] = cyc; med_n[0]++; end
            if (medir_b && med_n[1] < 64) begin med_cyc[1][med_n[1]] = cyc; med_n[1]++; end
            if (tx_a && tx_n[0] < 64) begin tx_cyc[0][tx_n[0]] = cyc; tx_sel[0][tx_n[0]] = int'(sel_a); tx_n[0]++; end
            if (tx_b && tx_n[1] < 64) begin tx_cyc[1][tx_n[1]] = cyc; tx_sel[1][tx_n[1]] = int'(sel_b); tx_n[1]++; end
            if (pro_a && pro_n[0] < 64) begin pro_cyc[0][pro_n[0]] = cyc; pro_n[0]++; end
            if (pro_b && pro_n[1] < 64) begin pro_cyc[1][pro_n[1]] = cyc; pro_n[1]++; end
        end
    end

    task automatic clear_log();
        for (int d = 0; d < 2; d++) begin med_n[d] = 0; tx_n[d] = 0; pro_n[d] = 0; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if ({medir_a, tx_a, pro_a, tmo_a} !== 4'b0000) begin n_err++; $display("FAIL reset_outs_a: got %b want 0000", {medir_a, tx_a, pro_a, tmo_a}); end
        n_vec++; if (sel_a !== 2'd2) begin n_err++; $display("FAIL reset_sel_a: got %0d want 2", sel_a); end
        n_vec++; if (sel_b !== 3'd4) begin n_err++; $display("FAIL reset_sel_b: got %0d want 4", sel_b); end
        n_vec++; if (db_a !== 4'h0 || db_b !== 4'h0) begin n_err++; $display("FAIL reset_db: got %h/%h want 0/0", db_a, db_b); end
        rst_n = 1'b1;
        clear_log();
        repeat (5) @(negedge clk);
        n_vec++; if (med_n[0] != 0 || db_a !== 4'h0) begin n_err++; $display("FAIL idle_no_start: got medir %0d db %h want 0 0", med_n[0], db_a); end
    endtask

    // one frame on both instances; expectations from the frame timing model
    task automatic test_frame(input int D, input int R, input bit hold);
        int c, m, b, nn, nch, db, exp_c, exp_s;
        rsp_dly = R; meas_dly = D; meas_en = 1'b1; spur_en = hold;
        @(negedge clk);
        clear_log();
        mens_a = 1'b1; mens_b = 1'b1; c = cyc; m = c + 1;
        if (!hold) begin @(negedge clk); mens_a = 1'b0; mens_b = 1'b0; end
        b = 0;
        while ((pro_n[0] == 0 || pro_n[1] == 0) && b < 500) begin
            @(negedge clk);
            if (pro_a) mens_a = 1'b0;
            if (pro_b) mens_b = 1'b0;
            b++;
        end
        mens_a = 1'b0; mens_b = 1'b0; spur_en = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (b >= 500) begin n_err++; $display("FAIL frame_done: got %0d cycles want <500", b); end
        for (int d = 0; d < 2; d++) begin
            nn  = (d == 0) ? 3 : 5;
            nch = (d == 0) ? 4 : 5;
            db  = (d == 0) ? int'(db_a) : int'(db_b);
            n_vec++; if (med_n[d] != 1) begin n_err++; $display("FAIL medir_count dut%0d: got %0d want 1", d, med_n[d]); end
            n_vec++; if (med_n[d] > 0 && med_cyc[d][0] != m) begin n_err++; $display("FAIL medir_latency dut%0d: got %0d want %0d", d, med_cyc[d][0] - c, 1); end
            n_vec++; if (tx_n[d] != nch) begin n_err++; $display("FAIL tx_count dut%0d: got %0d want %0d", d, tx_n[d], nch); end
            for (int k = 0; k < nch && k < tx_n[d]; k++) begin
                exp_s = (k < nn) ? nn - 1 - k : nn;
                exp_c = m + D + 1 + k * (R + 1);
                n_vec++; if (tx_sel[d][k] != exp_s) begin n_err++; $display("FAIL tx_sel[%0d] dut%0d: got %0d want %0d", k, d, tx_sel[d][k], exp_s); end
                n_vec++; if (tx_cyc[d][k] != exp_c) begin n_err++; $display("FAIL tx_time[%0d] dut%0d: got %0d want %0d", k, d, tx_cyc[d][k] - m, exp_c - m); end
            end
            exp_c = m + D + 1 + nch * (R + 1);
            n_vec++; if (pro_n[d] != 1) begin n_err++; $display("FAIL pronto_count dut%0d: got %0d want 1", d, pro_n[d]); end
            n_vec++; if (pro_n[d] > 0 && pro_cyc[d][0] != exp_c) begin n_err++; $display("FAIL pronto_time dut%0d: got %0d want %0d", d, pro_cyc[d][0] - m, exp_c - m); end
            n_vec++; if (db != 0) begin n_err++; $display("FAIL end_state dut%0d: got %0h want 0", d, db); end
        end
    endtask

    task automatic test_single_shot();
        test_frame(5, 3, 1'b0);
    endtask

    task automatic test_random_frames();
        repeat (4) test_frame($urandom_range(12, 1), $urandom_range(4, 1), 1'b0);
    endtask

    task automatic test_timeout();
        int c, m, b;
        meas_en = 1'b0;
        @(negedge clk);
        clear_log();
        mens_a = 1'b1; mens_b = 1'b1; c = cyc; m = c + 1;
        @(negedge clk); mens_a = 1'b0; mens_b = 1'b0;
        while (cyc < m + TMO) @(negedge clk);
        n_vec++; if (db_a !== 4'h2 || tmo_a !== 1'b0) begin n_err++; $display("FAIL tmo_last_wait: got db %h tmo %b want 2 0", db_a, tmo_a); end
        @(negedge clk);
        n_vec++; if (db_a !== 4'hE || tmo_a !== 1'b1) begin n_err++; $display("FAIL tmo_erro_a: got db %h tmo %b want E 1", db_a, tmo_a); end
        n_vec++; if (db_b !== 4'hE || tmo_b !== 1'b1) begin n_err++; $display("FAIL tmo_erro_b: got db %h tmo %b want E 1", db_b, tmo_b); end
        @(negedge clk);
        n_vec++; if (db_a !== 4'h0 || tmo_a !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got db %h tmo %b want 0 1", db_a, tmo_a); end
        n_vec++; if (tx_n[0] != 0 || tx_n[1] != 0) begin n_err++; $display("FAIL tmo_no_tx: got %0d/%0d want 0/0", tx_n[0], tx_n[1]); end
        // measurement arriving on the last allowed cycle beats the timeout
        meas_en = 1'b1; meas_dly = TMO; rsp_dly = 2;
        @(negedge clk);
        clear_log();
        mens_a = 1'b1; mens_b = 1'b1; c = cyc; m = c + 1;
        @(negedge clk); mens_a = 1'b0; mens_b = 1'b0;
        while (cyc < m + 1) @(negedge clk);
        n_vec++; if (tmo_a !== 1'b0 || tmo_b !== 1'b0) begin n_err++; $display("FAIL tmo_cleared: got %b%b want 00", tmo_a, tmo_b); end
        while (cyc < m + TMO + 1) @(negedge clk);
        n_vec++; if (db_a !== 4'h3 || tmo_a !== 1'b0) begin n_err++; $display("FAIL tmo_edge_a: got db %h tmo %b want 3 0", db_a, tmo_a); end
        n_vec++; if (db_b !== 4'h3 || tmo_b !== 1'b0) begin n_err++; $display("FAIL tmo_edge_b: got db %h tmo %b want 3 0", db_b, tmo_b); end
        b = 0;
        while ((pro_n[0] == 0 || pro_n[1] == 0) && b < 300) begin @(negedge clk); b++; end
        n_vec++; if (pro_n[0] != 1 || pro_n[1] != 1) begin n_err++; $display("FAIL tmo_edge_pronto: got %0d/%0d want 1/1", pro_n[0], pro_n[1]); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_continuous();
        int b;
        rsp_dly = $urandom_range(3, 1); meas_dly = $urandom_range(6, 1); meas_en = 1'b1;
        @(negedge clk);
        clear_log();
        continuo = 1'b1; mens_a = 1'b1; mens_b = 1'b1;
        @(negedge clk); mens_a = 1'b0; mens_b = 1'b0;
        b = 0;
        while (pro_n[0] < 3 && b < 1000) begin @(negedge clk); b++; end
        n_vec++; if (b >= 1000) begin n_err++; $display("FAIL cont_frames: got %0d prontos want 3", pro_n[0]); end
        b = 0;
        while (db_a !== 4'h6 && b < 5) begin @(negedge clk); b++; end
        continuo = 1'b0;
        repeat (80) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k + 1 < med_n[d] && k < pro_n[d]; k++) begin
                n_vec++;
                if (med_cyc[d][k + 1] - pro_cyc[d][k] != PER + 1) begin
                    n_err++; $display("FAIL cont_gap[%0d] dut%0d: got %0d want %0d", k, d, med_cyc[d][k + 1] - pro_cyc[d][k], PER + 1);
                end
            end
            n_vec++; if (med_n[d] != pro_n[d]) begin n_err++; $display("FAIL cont_stop dut%0d: got medir %0d want %0d", d, med_n[d], pro_n[d]); end
        end
        n_vec++; if (med_n[0] != 3) begin n_err++; $display("FAIL cont_medir_a: got %0d want 3", med_n[0]); end
        n_vec++; if (med_n[1] < 2) begin n_err++; $display("FAIL cont_medir_b: got %0d want >=2", med_n[1]); end
        n_vec++; if (db_a !== 4'h0 || db_b !== 4'h0) begin n_err++; $display("FAIL cont_idle: got %h/%h want 0/0", db_a, db_b); end
    endtask

    task automatic test_async_reset();
        int b;
        rsp_dly = 4; meas_dly = 2; meas_en = 1'b1;
        @(negedge clk);
        clear_log();
        mens_a = 1'b1; mens_b = 1'b1;
        @(negedge clk); mens_a = 1'b0; mens_b = 1'b0;
        b = 0;
        while (!(db_a === 4'h4 && sel_a === 2'd1) && b < 100) begin @(negedge clk); b++; end
        n_vec++; if (b >= 100) begin n_err++; $display("FAIL areset_reach: got db %h want 4", db_a); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({medir_a, tx_a, pro_a, tmo_a} !== 4'b0000) begin n_err++; $display("FAIL areset_outs_a: got %b want 0000", {medir_a, tx_a, pro_a, tmo_a}); end
        n_vec++; if (db_a !== 4'h0 || sel_a !== 2'd2) begin n_err++; $display("FAIL areset_a: got db %h sel %0d want 0 2", db_a, sel_a); end
        n_vec++; if (db_b !== 4'h0 || sel_b !== 3'd4) begin n_err++; $display("FAIL areset_b: got db %h sel %0d want 0 4", db_b, sel_b); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        test_frame($urandom_range(12, 1), $urandom_range(4, 1), 1'b0);
    endtask

    task automatic test_hold_spurious();
        test_frame($urandom_range(12, 1), $urandom_range(4, 1), 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_random_frames();
        test_timeout();
        test_continuous();
        test_async_reset();
        test_hold_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
